// File: rtl/conv_stream_controller.sv
`default_nettype none
// ============================================================================
// Module      : conv_stream_controller
// Description : Frame sequencer feeding spatial_conv_core from a multi-channel
//               image RAM and serialising kernel results into an output RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_stream_controller #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int N_ROWS      = 100,
    parameter int N_COLS      = 100,
    parameter int N_CHANNELS  = 3,
    parameter int N_KERNELS   = 1,
    parameter int OUT_SIZE    = 2401,
    parameter int RAM_LATENCY = 1,
    parameter int LAYOUT      = 0
) (
    input  logic                             clock_i,
    input  logic                             reset_ni,
    input  logic                             start_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [15:0]                      frame_count_o,
    output logic                             overrun_o,
    output logic [ADDR_WIDTH-1:0]            rd_addr_o,
    input  logic [DATA_WIDTH-1:0]            rd_data_i,
    output logic [N_CHANNELS*DATA_WIDTH-1:0] ch_data_o,
    output logic [N_CHANNELS-1:0]            ch_valid_o,
    input  logic [N_CHANNELS-1:0]            ch_hold_i,
    input  logic [N_KERNELS*DATA_WIDTH-1:0]  res_data_i,
    input  logic [N_KERNELS-1:0]             res_valid_i,
    output logic [ADDR_WIDTH-1:0]            wr_addr_o,
    output logic [DATA_WIDTH-1:0]            wr_data_o,
    output logic                             wr_en_o
);

    localparam int c_N_PIX  = N_ROWS * N_COLS;
    localparam int c_PIX_W  = $clog2(c_N_PIX + 1);
    localparam int c_CH_W   = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int c_K_W    = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1;
    localparam int c_IDX_W  = $clog2(OUT_SIZE + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_CH_W-1:0]   r_ch;
    logic [2:0]          r_lat;
    logic [c_PIX_W-1:0]  r_pix [N_CHANNELS];

    logic [DATA_WIDTH-1:0] r_buf_data [N_KERNELS];
    logic [N_KERNELS-1:0]  r_buf_mask;
    logic [c_IDX_W-1:0]    r_out_idx [N_KERNELS];

    logic [c_PIX_W-1:0]    w_cur_pix;
    logic                  w_cur_done;
    logic                  w_all_done;
    logic [c_CH_W-1:0]     w_ch_next;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_frame_start;

    logic [c_K_W-1:0]      w_sel;
    logic [N_KERNELS-1:0]  w_sel_onehot;
    logic                  w_buf_empty;
    logic                  w_accept;
    logic                  w_out_full;
    logic                  w_sel_room;
    logic [ADDR_WIDTH-1:0] w_wr_addr;

    assign w_cur_pix     = r_pix[r_ch];
    assign w_cur_done    = (w_cur_pix == c_PIX_W'(c_N_PIX));
    assign w_ch_next     = (r_ch == c_CH_W'(N_CHANNELS - 1)) ? '0 : r_ch + c_CH_W'(1);
    assign w_frame_start = (r_state == ST_IDLE) && start_i;

    always_comb begin
        w_all_done = 1'b1;
        for (int c = 0; c < N_CHANNELS; c++) begin
            if (r_pix[c] != c_PIX_W'(c_N_PIX)) begin
                w_all_done = 1'b0;
            end
        end
    end

    // Planar: channel-major planes. Interleaved: channels adjacent per pixel.
    always_comb begin
        if (LAYOUT == 0) begin
            w_rd_addr = ADDR_WIDTH'(r_ch) * ADDR_WIDTH'(c_N_PIX) + ADDR_WIDTH'(w_cur_pix);
        end else begin
            w_rd_addr = ADDR_WIDTH'(w_cur_pix) * ADDR_WIDTH'(N_CHANNELS) + ADDR_WIDTH'(r_ch);
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state       <= ST_IDLE;
            r_ch          <= '0;
            r_lat         <= '0;
            rd_addr_o     <= '0;
            ch_data_o     <= '0;
            ch_valid_o    <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            frame_count_o <= '0;
            for (int c = 0; c < N_CHANNELS; c++) begin
                r_pix[c] <= '0;
            end
        end else begin
            ch_valid_o <= '0;
            done_o     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= ST_SELECT;
                        r_ch    <= '0;
                        busy_o  <= 1'b1;
                        for (int c = 0; c < N_CHANNELS; c++) begin
                            r_pix[c] <= '0;
                        end
                    end
                end
                ST_SELECT: begin
                    if (w_all_done) begin
                        r_state <= ST_DRAIN;
                    end else if (w_cur_done || ch_hold_i[r_ch]) begin
                        r_ch <= w_ch_next;
                    end else begin
                        rd_addr_o <= w_rd_addr;
                        r_lat     <= 3'(RAM_LATENCY - 1);
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_lat == 3'd0) begin
                        ch_data_o[r_ch*DATA_WIDTH +: DATA_WIDTH] <= rd_data_i;
                        ch_valid_o[r_ch] <= 1'b1;
                        r_pix[r_ch]      <= w_cur_pix + c_PIX_W'(1);
                        r_ch             <= w_ch_next;
                        r_state          <= ST_SELECT;
                    end else begin
                        r_lat <= r_lat - 3'd1;
                    end
                end
                ST_DRAIN: begin
                    if (w_out_full && w_buf_empty) begin
                        done_o        <= 1'b1;
                        frame_count_o <= frame_count_o + 16'd1;
                        busy_o        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Lowest pending kernel drains first.
    always_comb begin
        w_sel = '0;
        for (int k = N_KERNELS - 1; k >= 0; k--) begin
            if (r_buf_mask[k]) begin
                w_sel = c_K_W'(k);
            end
        end
        w_sel_onehot = r_buf_mask & (~r_buf_mask + N_KERNELS'(1));
    end

    always_comb begin
        w_out_full = 1'b1;
        for (int k = 0; k < N_KERNELS; k++) begin
            if (r_out_idx[k] != c_IDX_W'(OUT_SIZE)) begin
                w_out_full = 1'b0;
            end
        end
    end

    assign w_buf_empty = (r_buf_mask == '0);
    // Buffer frees this cycle if nothing remains after the current drain.
    assign w_accept    = ((r_buf_mask & ~w_sel_onehot) == '0);
    assign w_sel_room  = (r_out_idx[w_sel] != c_IDX_W'(OUT_SIZE));
    assign w_wr_addr   = ADDR_WIDTH'(w_sel) * ADDR_WIDTH'(OUT_SIZE) + ADDR_WIDTH'(r_out_idx[w_sel]);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_buf_mask <= '0;
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            overrun_o  <= 1'b0;
            for (int k = 0; k < N_KERNELS; k++) begin
                r_buf_data[k] <= '0;
                r_out_idx[k]  <= '0;
            end
        end else begin
            wr_en_o <= 1'b0;
            if (!w_buf_empty && w_sel_room) begin
                wr_en_o          <= 1'b1;
                wr_addr_o        <= w_wr_addr;
                wr_data_o        <= r_buf_data[w_sel];
                r_out_idx[w_sel] <= r_out_idx[w_sel] + c_IDX_W'(1);
            end
            if ((|res_valid_i) && w_accept) begin
                r_buf_mask <= res_valid_i;
                for (int k = 0; k < N_KERNELS; k++) begin
                    r_buf_data[k] <= res_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end else begin
                r_buf_mask <= r_buf_mask & ~w_sel_onehot;
                if (|res_valid_i) begin
                    overrun_o <= 1'b1;
                end
            end
            if (w_frame_start) begin
                for (int k = 0; k < N_KERNELS; k++) begin
                    r_out_idx[k] <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_stream_controller
// Description : Scoreboard bench for conv_stream_controller (planar/L=1 and
//               interleaved/L=3 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_stream_controller;

    localparam int c_CH   = 3;
    localparam int c_OS   = 4;
    localparam int c_NPIX = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, start_b;
    logic busy_a, busy_b, done_a, done_b, ovr_a, ovr_b, wr_en_a, wr_en_b;
    logic [15:0] fc_a, fc_b, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [31:0] rd_data_a, rd_data_b, wr_data_a, wr_data_b;
    logic [95:0] ch_data_a, ch_data_b;
    logic [2:0]  ch_valid_a, ch_valid_b, hold_a, hold_b;
    logic [63:0] res_data_a, res_data_b;
    logic [1:0]  res_valid_a, res_valid_b;
    logic [15:0] d1_b, d2_b;

    // RAM[a] = a; instance B sees a three-cycle read path.
    assign rd_data_a = {16'h0, rd_addr_a};
    always @(posedge clk) begin
        d1_b <= rd_addr_b;
        d2_b <= d1_b;
    end
    assign rd_data_b = {16'h0, d2_b};
    assign hold_b = 3'b000;

    conv_stream_controller #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .N_ROWS(4), .N_COLS(4), .N_CHANNELS(3),
        .N_KERNELS(2), .OUT_SIZE(c_OS), .RAM_LATENCY(1), .LAYOUT(0)
    ) u_dut_a (
        .clock_i(clk), .reset_ni(rst_n), .start_i(start_a), .busy_o(busy_a),
        .done_o(done_a), .frame_count_o(fc_a), .overrun_o(ovr_a),
        .rd_addr_o(rd_addr_a), .rd_data_i(rd_data_a), .ch_data_o(ch_data_a),
        .ch_valid_o(ch_valid_a), .ch_hold_i(hold_a), .res_data_i(res_data_a),
        .res_valid_i(res_valid_a), .wr_addr_o(wr_addr_a), .wr_data_o(wr_data_a),
        .wr_en_o(wr_en_a)
    );

    conv_stream_controller #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .N_ROWS(4), .N_COLS(4), .N_CHANNELS(3),
        .N_KERNELS(2), .OUT_SIZE(c_OS), .RAM_LATENCY(3), .LAYOUT(1)
    ) u_dut_b (
        .clock_i(clk), .reset_ni(rst_n), .start_i(start_b), .busy_o(busy_b),
        .done_o(done_b), .frame_count_o(fc_b), .overrun_o(ovr_b),
        .rd_addr_o(rd_addr_b), .rd_data_i(rd_data_b), .ch_data_o(ch_data_b),
        .ch_valid_o(ch_valid_b), .ch_hold_i(hold_b), .res_data_i(res_data_b),
        .res_valid_i(res_valid_b), .wr_addr_o(wr_addr_b), .wr_data_o(wr_data_b),
        .wr_en_o(wr_en_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboards
    int          pix_q_a [c_CH][$];
    logic [47:0] wr_q_a [$];
    logic [47:0] wr_q_b [$];
    int          exp_idx_a [2];
    int          exp_idx_b [2];
    logic [31:0] ld_a [c_CH];

    int cyc = 0;
    int strobes_a, writes_a, dones_a, last_a, exp_ch_a, first1_a, first_ch_a, first_data_a;
    int strobes_b, writes_b, dones_b, last_b, ch2cnt_b, ch2_second_b;
    bit order_en_a;
    int hold_cyc_a = 0;
    int hold_viol, hold_other;

    always @(posedge clk) hold_cyc_a <= hold_a[1] ? hold_cyc_a + 1 : 0;

    always @(negedge clk) begin : mon_a
        logic [63:0] e;
        cyc++;
        if (ch_valid_a != 3'b000) begin
            check("onehot_a", 64'($countones(ch_valid_a)), 64'd1);
            for (int c = 0; c < c_CH; c++) begin
                if (ch_valid_a[c]) begin
                    e = (pix_q_a[c].size() > 0) ? 64'(pix_q_a[c].pop_front()) : '1;
                    check("pixel_a", 64'(ch_data_a[c*32 +: 32]), e);
                    for (int d = 0; d < c_CH; d++) begin
                        if (d != c) check("data_hold_a", 64'(ch_data_a[d*32 +: 32]), 64'(ld_a[d]));
                    end
                    ld_a[c] = ch_data_a[c*32 +: 32];
                    if (strobes_a == 0) begin
                        first_ch_a   = c;
                        first_data_a = int'(ch_data_a[c*32 +: 32]);
                    end
                    if (c == 1 && first1_a < 0) first1_a = int'(ch_data_a[32 +: 32]);
                    if (order_en_a) begin
                        check("order_a", 64'(c), 64'(exp_ch_a));
                        if (last_a >= 0) check("spacing_a", 64'(cyc - last_a), 64'd2);
                    end
                    if (hold_cyc_a >= 2) begin
                        if (c == 1) hold_viol++;
                        else hold_other++;
                    end
                    exp_ch_a = (c + 1) % c_CH;
                    last_a   = cyc;
                    strobes_a++;
                end
            end
        end
        if (wr_en_a) begin
            e = (wr_q_a.size() > 0) ? 64'(wr_q_a.pop_front()) : '1;
            check("write_a", {16'h0, wr_addr_a, wr_data_a}, e);
            writes_a++;
        end
        if (done_a) dones_a++;
    end

    always @(negedge clk) begin : mon_b
        logic [63:0] e;
        if (ch_valid_b != 3'b000) begin
            check("onehot_b", 64'($countones(ch_valid_b)), 64'd1);
            for (int c = 0; c < c_CH; c++) begin
                if (ch_valid_b[c]) begin
                    check("chan_b", 64'(c), 64'(strobes_b % c_CH));
                    check("addr_seq_b", 64'(ch_data_b[c*32 +: 32]), 64'(strobes_b));
                    if (last_b >= 0) check("spacing_b", 64'(cyc - last_b), 64'd4);
                    if (c == 2) begin
                        ch2cnt_b++;
                        if (ch2cnt_b == 2) ch2_second_b = int'(ch_data_b[64 +: 32]);
                    end
                    last_b = cyc;
                    strobes_b++;
                end
            end
        end
        if (wr_en_b) begin
            e = (wr_q_b.size() > 0) ? 64'(wr_q_b.pop_front()) : '1;
            check("write_b", {16'h0, wr_addr_b, wr_data_b}, e);
            writes_b++;
        end
        if (done_b) dones_b++;
    end

    function automatic int leftover_a();
        int n = wr_q_a.size();
        for (int c = 0; c < c_CH; c++) n += pix_q_a[c].size();
        return n;
    endfunction

    task automatic start_frame_a();
        for (int c = 0; c < c_CH; c++) begin
            pix_q_a[c].delete();
            for (int p = 0; p < c_NPIX; p++) pix_q_a[c].push_back(c * c_NPIX + p);
        end
        wr_q_a.delete();
        exp_idx_a = '{0, 0};
        strobes_a = 0; writes_a = 0; dones_a = 0; last_a = -1; exp_ch_a = 0;
        first1_a = -1; first_ch_a = -1; first_data_a = -1;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
    endtask

    task automatic send_result(input bit inst_b, input logic [1:0] mask, input bit accept, input int gap);
        logic [31:0] d [2];
        d[0] = $urandom;
        d[1] = $urandom;
        if (accept) begin
            for (int k = 0; k < 2; k++) begin
                if (mask[k] && !inst_b && exp_idx_a[k] < c_OS) begin
                    wr_q_a.push_back({16'(k * c_OS + exp_idx_a[k]), d[k]});
                    exp_idx_a[k]++;
                end
                if (mask[k] && inst_b && exp_idx_b[k] < c_OS) begin
                    wr_q_b.push_back({16'(k * c_OS + exp_idx_b[k]), d[k]});
                    exp_idx_b[k]++;
                end
            end
        end
        if (inst_b) begin
            res_data_b = {d[1], d[0]}; res_valid_b = mask;
        end else begin
            res_data_a = {d[1], d[0]}; res_valid_a = mask;
        end
        tick(1);
        res_valid_a = 2'b00;
        res_valid_b = 2'b00;
        tick(gap);
    endtask

    task automatic wait_done_a(input string tag);
        for (int i = 0; i < 1000 && dones_a == 0; i++) tick(1);
        check(tag, 64'(dones_a != 0), 64'd1);
        tick(4);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_busy"},     64'(busy_a),     64'd0);
        check({tag, "_done"},     64'(done_a),     64'd0);
        check({tag, "_fc"},       64'(fc_a),       64'd0);
        check({tag, "_ovr"},      64'(ovr_a),      64'd0);
        check({tag, "_rd_addr"},  64'(rd_addr_a),  64'd0);
        check({tag, "_ch_valid"}, 64'(ch_valid_a), 64'd0);
        check({tag, "_ch_data"},  64'(|ch_data_a), 64'd0);
        check({tag, "_wr_en"},    64'(wr_en_a),    64'd0);
        check({tag, "_wr_addr"},  64'(wr_addr_a),  64'd0);
        check({tag, "_wr_data"},  64'(wr_data_a),  64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; hold_a = 3'b000;
        res_valid_a = 2'b00; res_valid_b = 2'b00; res_data_a = '0; res_data_b = '0;
        for (int c = 0; c < c_CH; c++) ld_a[c] = '0;
        strobes_b = 0; writes_b = 0; dones_b = 0; last_b = -1; ch2cnt_b = 0; ch2_second_b = -1;
        hold_viol = 0; hold_other = 0; order_en_a = 1'b0;
        tick(3);
        check_reset_a("rst");
        check("rst_busy_b", 64'(busy_b), 64'd0);
        check("rst_fc_b",   64'(fc_b),   64'd0);
        rst_n = 1'b1;
        tick(2);

        // Frame 1: plain round-robin, five result pairs (fifth is past OUT_SIZE)
        order_en_a = 1'b1;
        start_frame_a();
        check("busy_after_start", 64'(busy_a), 64'd1);
        for (int i = 0; i < 5; i++) send_result(1'b0, 2'b11, 1'b1, 2);
        wait_done_a("f1_done_seen");
        check("f1_dones",    64'(dones_a),    64'd1);
        check("f1_fc",       64'(fc_a),       64'd1);
        check("f1_strobes",  64'(strobes_a),  64'd48);
        check("f1_writes",   64'(writes_a),   64'd8);
        check("f1_ch1_first", 64'(first1_a),  64'd16);
        check("f1_left",     64'(leftover_a()), 64'd0);
        check("f1_busy",     64'(busy_a),     64'd0);
        check("f1_ovr",      64'(ovr_a),      64'd0);

        // Frame 2: channel 1 held for ten cycles mid-frame
        order_en_a = 1'b0;
        start_frame_a();
        for (int i = 0; i < 4; i++) send_result(1'b0, 2'b11, 1'b1, 2);
        for (int i = 0; i < 200 && strobes_a < 20; i++) tick(1);
        hold_viol = 0; hold_other = 0;
        hold_a[1] = 1'b1;
        tick(10);
        hold_a[1] = 1'b0;
        check("hold_no_ch1", 64'(hold_viol), 64'd0);
        check("hold_others", 64'(hold_other >= 2), 64'd1);
        wait_done_a("f2_done_seen");
        check("f2_dones",   64'(dones_a),   64'd1);
        check("f2_fc",      64'(fc_a),      64'd2);
        check("f2_strobes", 64'(strobes_a), 64'd48);
        check("f2_left",    64'(leftover_a()), 64'd0);

        // Frame 3: back-to-back pair overruns; later pairs land as the buffer frees
        order_en_a = 1'b1;
        start_frame_a();
        check("f3_pre_ovr", 64'(ovr_a), 64'd0);
        send_result(1'b0, 2'b11, 1'b1, 0);
        send_result(1'b0, 2'b11, 1'b0, 2);
        check("f3_ovr_set", 64'(ovr_a), 64'd1);
        for (int i = 0; i < 3; i++) send_result(1'b0, 2'b11, 1'b1, 1);
        wait_done_a("f3_done_seen");
        check("f3_ovr_sticky", 64'(ovr_a),    64'd1);
        check("f3_writes",     64'(writes_a), 64'd8);
        check("f3_fc",         64'(fc_a),     64'd3);
        check("f3_left",       64'(leftover_a()), 64'd0);

        // Frame 4: reset while a read is outstanding
        start_frame_a();
        for (int i = 0; i < 200 && strobes_a < 5; i++) tick(1);
        rst_n = 1'b0;
        #1;
        check_reset_a("midwait");
        tick(3);
        check("midwait_no_done", 64'(dones_a), 64'd0);
        for (int c = 0; c < c_CH; c++) ld_a[c] = '0;
        rst_n = 1'b1;
        tick(1);

        // Frame 5: restart from pixel 0
        start_frame_a();
        for (int i = 0; i < 4; i++) send_result(1'b0, 2'b11, 1'b1, 2);
        wait_done_a("f5_done_seen");
        check("f5_first_ch",   64'(first_ch_a),   64'd0);
        check("f5_first_data", 64'(first_data_a), 64'd0);
        check("f5_strobes",    64'(strobes_a),    64'd48);
        check("f5_fc",         64'(fc_a),         64'd1);
        check("f5_dones",      64'(dones_a),      64'd1);
        check("f5_left",       64'(leftover_a()), 64'd0);

        // Instance B: interleaved layout, three-cycle RAM
        exp_idx_b = '{0, 0};
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) send_result(1'b1, 2'b11, 1'b1, 2);
        for (int i = 0; i < 1000 && dones_b == 0; i++) tick(1);
        check("b_done_seen", 64'(dones_b != 0), 64'd1);
        tick(4);
        check("b_dones",      64'(dones_b),      64'd1);
        check("b_fc",         64'(fc_b),         64'd1);
        check("b_strobes",    64'(strobes_b),    64'd48);
        check("b_ch2_second", 64'(ch2_second_b), 64'd5);
        check("b_writes",     64'(writes_b),     64'd8);
        check("b_left",       64'(wr_q_b.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_stream_controller.md
Name: conv_stream_controller

Overview:
- Parametrised frame sequencer between a multi-channel input image RAM, spatial_conv_core and an output image RAM.
- Streams every pixel of every channel from one read port to the core, round-robin over channels, honouring per-channel hold and a configurable RAM read latency.
- Serialises the N_KERNELS parallel results into per-kernel regions of the output RAM.
- Signals completion once per frame and supports planar or channel-interleaved input layout.

Parameters:
- ADDR_WIDTH, 16, RAM address width.
- DATA_WIDTH, 32, pixel/result word width (fixed-point, opaque here).
- N_ROWS, 100, input rows.
- N_COLS, 100, input columns.
- N_CHANNELS, 3, input channels.
- N_KERNELS, 1, parallel result streams.
- OUT_SIZE, 2401, words written per kernel per frame.
- RAM_LATENCY, 1, cycles from rd_addr_o to valid rd_data_i (1..4).
- LAYOUT, 0, 0 = planar (addr = c*N_ROWS*N_COLS + p), 1 = interleaved (addr = p*N_CHANNELS + c).

Ports:
- clock_i  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- start_i  in  1  begin frame; ignored while busy_o=1
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle pulse at frame end
- frame_count_o  out  16  completed frames, wraps at 2^16
- overrun_o  out  1  sticky: result arrived while write buffer still draining
- rd_addr_o  out  ADDR_WIDTH  input RAM read address
- rd_data_i  in  DATA_WIDTH  input RAM read data
- ch_data_o  out  N_CHANNELS*DATA_WIDTH  per-channel pixel to core; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
- ch_valid_o  out  N_CHANNELS  one-cycle strobe per delivered pixel
- ch_hold_i  in  N_CHANNELS  core back-pressure per channel
- res_data_i  in  N_KERNELS*DATA_WIDTH  core results
- res_valid_i  in  N_KERNELS  result strobes
- wr_addr_o  out  ADDR_WIDTH  output RAM address
- wr_data_o  out  DATA_WIDTH  output RAM data
- wr_en_o  out  1  output RAM write enable

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, FSM=IDLE, all counters 0, overrun_o cleared. Reset mid-frame aborts the frame and emits no done_o.
- Feed FSM states:
  - IDLE: on start_i go to SELECT with channel c=0, busy_o=1.
  - SELECT: if pix[c]==N_ROWS*N_COLS or ch_hold_i[c]=1, advance c=(c+1) mod N_CHANNELS and stay in SELECT. Otherwise drive rd_addr_o per LAYOUT and go to WAIT. ch_hold_i is sampled only in SELECT.
  - WAIT: hold rd_addr_o for RAM_LATENCY cycles. On the last cycle latch rd_data_i into ch_data_o[c], pulse ch_valid_o[c], increment pix[c], advance c, return to SELECT.
  - When every pix[c]==N_ROWS*N_COLS, go to DRAIN.
  - DRAIN: wait until every out_idx[k]==OUT_SIZE and the write buffer is empty, then pulse done_o, increment frame_count_o, clear busy_o, go to IDLE.
- Feed properties:
  - One read outstanding at a time; peak rate 1 pixel per RAM_LATENCY+1 cycles.
  - At most one ch_valid_o bit is high in any cycle.
  - ch_data_o holds its value between strobes.
- Result writer (runs concurrently with feed):
  - When any res_valid_i bit is high and the buffer is empty, latch all words plus the valid mask.
  - Drain the buffer one valid kernel per cycle, lowest k first: wr_addr_o = k*OUT_SIZE + out_idx[k], wr_en_o=1, out_idx[k]++.
  - A kernel with out_idx[k]==OUT_SIZE is discarded without writing.
  - When res_valid_i is high while the buffer is non-empty, the new results are dropped and overrun_o sets.
  - A result arriving in the cycle the last buffered word drains is accepted.
- Address arithmetic is ADDR_WIDTH modulo; the integrator keeps N_CHANNELS*N_ROWS*N_COLS and N_KERNELS*OUT_SIZE within 2^ADDR_WIDTH.

Test Plan:
- N_ROWS=N_COLS=4, N_CHANNELS=3, LAYOUT=0, RAM_LATENCY=1, holds low, RAM[a]=a:
  - ch_valid_o cycles through channels 0,1,2.
  - Channel 1's first pixel is 16.
  - 48 strobes total, spaced 2 cycles apart.
- Same configuration with LAYOUT=1, RAM_LATENCY=3:
  - Addresses are 0,1,2,3,…; channel 2's second pixel reads address 5.
  - Strobes are spaced 4 cycles apart.
- Hold ch_hold_i[1]=1 for 10 cycles:
  - Channels 0 and 2 keep streaming; no channel-1 strobe during the hold.
  - Channel 1 resumes at the correct pixel index.
  - Frame totals are unchanged.
- N_KERNELS=2, OUT_SIZE=4, res_valid_i=2'b11 every 3 cycles:
  - Writes go to addresses 0,4,1,5,2,6,3,7.
  - A fifth pair produces no wr_en_o.
  - done_o pulses once and frame_count_o=1.
- res_valid_i=2'b11 on two consecutive cycles with N_KERNELS=2: overrun_o=1 stays set; only the first pair is written.
- Assert reset_ni=0 mid-WAIT:
  - All outputs go to 0 immediately; no done_o.
  - A subsequent start_i restarts from pixel 0.
